// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the register-file write port logic.
// No logic here: types and sizes only.
// No flow control here: consumers define their own handshakes.
package regfile_pkg;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;

  typedef enum logic {
    WB_CLEAR = 1'b0,
    WB_RUN   = 1'b1
  } wb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is honoured.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [2*N-1:0] req_rot;
  int             sum;

  // Rotate requests so ptr lands at bit 0, take the lowest set bit, map back modulo N.
  always_comb begin
    req_rot   = {req, req} >> ptr;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    sum       = 0;
    for (int k = 0; k < N; k++) begin
      if (!grant_any && req_rot[k]) begin
        grant_any = 1'b1;
        sum       = int'(ptr) + k;
        if (sum >= N) sum = sum - N;
      end
    end
    if (grant_any) begin
      grant_idx = IDX_W'(sum);
      grant     = {{(N-1){1'b0}}, 1'b1} << grant_idx;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Sole driver of the register-file write port: zero sweep of x1..x31, then round-robin writeback.
// Latency: an accepted request appears on rf_wen/rf_wsel/rf_wdata one cycle later.
// Backpressure: req_ready is the one-hot grant; zero during reset, the sweep and a clear_req cycle.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_sel,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      clear_req,
  output logic                      rf_wen,
  output logic [ADDR_W-1:0]         rf_wsel,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  wb_state_e          state, state_next;
  logic [ADDR_W-1:0]  cnt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   ptr_inc;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   gidx;
  logic               gany;
  logic               accept;

  logic [ADDR_W-1:0]  sel_arr  [NUM_REQ];
  logic [DATA_W-1:0]  data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign sel_arr[i]  = req_sel[i*ADDR_W +: ADDR_W];
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (gidx),
    .grant_any (gany)
  );

  // Grants are only offered in RUN, outside reset, and not while a clear is being requested.
  always_comb begin
    req_ready = '0;
    if (state == WB_RUN && !clear_req && !rst) req_ready = grant;
  end

  assign busy    = (state == WB_CLEAR);
  assign accept  = (state == WB_RUN) && !clear_req && gany;
  assign ptr_inc = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= WB_CLEAR;
    else     state <= state_next;
  end

  // Next state: leave CLEAR after index 31 is issued, re-enter on clear_req.
  always_comb begin
    state_next = state;
    case (state)
      WB_CLEAR: if (cnt == '1) state_next = WB_RUN;
      WB_RUN:   if (clear_req) state_next = WB_CLEAR;
      default:  state_next = WB_CLEAR;
    endcase
  end

  // Sweep counter, round-robin pointer and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= ADDR_W'(1);
      rr_ptr   <= '0;
      rf_wen   <= 1'b0;
      rf_wsel  <= '0;
      rf_wdata <= '0;
    end else if (state == WB_CLEAR) begin
      rf_wen   <= 1'b1;
      rf_wsel  <= cnt;
      rf_wdata <= '0;
      cnt      <= cnt + 1'b1;
    end else if (clear_req) begin
      cnt    <= ADDR_W'(1);
      rf_wen <= 1'b0;
    end else if (accept) begin
      // Writes to x0 complete the handshake but never reach the register file.
      rf_wen   <= (sel_arr[gidx] != '0);
      rf_wsel  <= sel_arr[gidx];
      rf_wdata <= data_arr[gidx];
      rr_ptr   <= ptr_inc;
    end else begin
      rf_wen <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int LAST = (1 << AW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_sel;
  logic [N*DW-1:0] req_data;
  logic            clear_req;
  logic            rf_wen;
  logic [AW-1:0]   rf_wsel;
  logic [DW-1:0]   rf_wdata;
  logic            busy;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sel   (req_sel),
    .req_data  (req_data),
    .clear_req (clear_req),
    .rf_wen    (rf_wen),
    .rf_wsel   (rf_wsel),
    .rf_wdata  (rf_wdata),
    .busy      (busy)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: sweep flag + next index, round-robin pointer, expected port contents.
  bit            m_known = 0;
  bit            m_sweep;
  int            m_next;
  int            m_ptr;
  bit            m_wen;
  logic [AW-1:0] m_wsel;
  logic [DW-1:0] m_wdata;

  // Observation log of port writes and busy samples taken after each edge.
  int wlog[$];
  int bcnt;

  typedef struct packed {
    logic [N-1:0]    valid;
    logic [N*AW-1:0] sel;
    logic [N*DW-1:0] data;
    logic [N-1:0]    exp_rdy;
    logic            exp_wen;
    logic [AW-1:0]   exp_wsel;
    logic [DW-1:0]   exp_wdata;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_grant(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // One clock: check combinational outputs, clock, advance model, check registered outputs.
  task automatic step(input bit r, input bit clr, output logic [N-1:0] rdy_seen);
    int g;
    logic [N-1:0] er;
    rst = r;
    clear_req = clr;
    #1;
    g  = (r || !m_known || m_sweep || clr) ? -1 : exp_grant(req_valid, m_ptr);
    er = (g >= 0) ? N'(1 << g) : '0;
    chk("ready", 64'(req_ready), 64'(er));
    if (m_known) chk("busy", 64'(busy), 64'(m_sweep));
    rdy_seen = req_ready;
    @(posedge clk);
    if (r) begin
      m_known = 1; m_sweep = 1; m_next = 1; m_ptr = 0;
      m_wen = 0; m_wsel = '0; m_wdata = '0;
    end else if (m_sweep) begin
      m_wen = 1; m_wsel = AW'(m_next); m_wdata = '0;
      if (m_next == LAST) m_sweep = 0;
      m_next++;
    end else if (clr) begin
      m_sweep = 1; m_next = 1; m_wen = 0;
    end else if (g >= 0) begin
      m_wsel  = req_sel[g*AW +: AW];
      m_wdata = req_data[g*DW +: DW];
      m_wen   = (m_wsel != '0);
      m_ptr   = (g + 1) % N;
    end else begin
      m_wen = 0;
    end
    #1;
    chk("rf_wen", 64'(rf_wen), 64'(m_wen));
    chk("rf_wsel", 64'(rf_wsel), 64'(m_wsel));
    chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
    chk("busy_post", 64'(busy), 64'(m_sweep));
    if (rf_wen) wlog.push_back(int'(rf_wsel));
    if (busy) bcnt++;
  endtask

  task automatic chk_sweep(input string nm);
    chk({nm, "_len"}, 64'(wlog.size()), 64'(LAST));
    chk({nm, "_busy_cycles"}, 64'(bcnt), 64'(LAST));
    for (int i = 0; i < wlog.size() && i < LAST; i++)
      chk({nm, "_idx"}, 64'(wlog[i]), 64'(i + 1));
  endtask

  logic [N-1:0] rs;
  bit           pend [N];
  logic [AW-1:0] psel [N];
  logic [DW-1:0] pdat [N];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Stimulus table starting at the first RUN cycle with rr_ptr = 0.
    tbl[0]  = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'hA2, 32'hA1, 32'hA0}, 3'b001, 1'b1, 5'd1, 32'hA0};
    tbl[1]  = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'hA2, 32'hA1, 32'hA0}, 3'b010, 1'b1, 5'd2, 32'hA1};
    tbl[2]  = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'hA2, 32'hA1, 32'hA0}, 3'b100, 1'b1, 5'd3, 32'hA2};
    tbl[3]  = '{3'b111, {5'd6, 5'd5, 5'd4}, {32'hB2, 32'hB1, 32'hB0}, 3'b001, 1'b1, 5'd4, 32'hB0};
    tbl[4]  = '{3'b111, {5'd6, 5'd5, 5'd4}, {32'hB2, 32'hB1, 32'hB0}, 3'b010, 1'b1, 5'd5, 32'hB1};
    tbl[5]  = '{3'b111, {5'd6, 5'd5, 5'd4}, {32'hB2, 32'hB1, 32'hB0}, 3'b100, 1'b1, 5'd6, 32'hB2};
    tbl[6]  = '{3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF}, 3'b001, 1'b1, 5'd5, 32'hDEADBEEF};
    tbl[7]  = '{3'b010, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h1234, 32'h0}, 3'b010, 1'b0, 5'd0, 32'h1234};
    tbl[8]  = '{3'b011, {5'd0, 5'd10, 5'd9}, {32'h0, 32'h10, 32'h99}, 3'b001, 1'b1, 5'd9, 32'h99};
    tbl[9]  = '{3'b010, {5'd0, 5'd10, 5'd0}, {32'h0, 32'h10, 32'h0}, 3'b010, 1'b1, 5'd10, 32'h10};
    tbl[10] = '{3'b000, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h0}, 3'b000, 1'b0, 5'd10, 32'h10};
    tbl[11] = '{3'b100, {5'd7, 5'd0, 5'd0}, {32'h77, 32'h0, 32'h0}, 3'b100, 1'b1, 5'd7, 32'h77};

    req_valid = '0; req_sel = '0; req_data = '0; clear_req = 1'b0; rst = 1'b1;

    // Reset and the power-on sweep.
    wlog.delete(); bcnt = 0;
    step(1, 0, rs);
    chk("reset_wen", 64'(rf_wen), 64'(0));
    chk("reset_busy", 64'(busy), 64'(1));
    for (int i = 0; i < LAST; i++) step(0, 0, rs);
    chk_sweep("init_sweep");
    chk("sweep_done_busy", 64'(busy), 64'(0));

    // Table-driven run phase.
    for (int i = 0; i < 12; i++) begin
      req_valid = tbl[i].valid; req_sel = tbl[i].sel; req_data = tbl[i].data;
      step(0, 0, rs);
      chk("tbl_ready", 64'(rs), 64'(tbl[i].exp_rdy));
      chk("tbl_wen", 64'(rf_wen), 64'(tbl[i].exp_wen));
      chk("tbl_wsel", 64'(rf_wsel), 64'(tbl[i].exp_wsel));
      chk("tbl_wdata", 64'(rf_wdata), 64'(tbl[i].exp_wdata));
    end

    // clear_req while requester 2 waits with sel 7: previous write still shown, sweep first.
    req_valid = 3'b100; req_sel = {5'd7, 5'd0, 5'd0}; req_data = {32'hC1EA, 32'h0, 32'h0};
    #1;
    chk("clear_prev_wen", 64'(rf_wen), 64'(1));
    chk("clear_prev_wsel", 64'(rf_wsel), 64'(7));
    wlog.delete(); bcnt = 0;
    step(0, 1, rs);
    chk("clear_ready", 64'(rs), 64'(0));
    chk("clear_wen", 64'(rf_wen), 64'(0));
    begin
      int n = 0;
      while (busy && n < 40) begin step(0, 0, rs); n++; end
      chk("clear_sweep_timeout", 64'(n < 40), 64'(1));
    end
    step(0, 0, rs);
    chk("post_clear_grant", 64'(rs), 64'(3'b100));
    chk("post_clear_log_len", 64'(wlog.size()), 64'(LAST + 1));
    if (wlog.size() == LAST + 1) begin
      chk("post_clear_last_sweep", 64'(wlog[LAST - 1]), 64'(LAST));
      chk("post_clear_req_write", 64'(wlog[LAST]), 64'(7));
    end
    chk("post_clear_wdata", 64'(rf_wdata), 64'(32'hC1EA));

    // Reset in RUN with everyone valid, then reset again mid-sweep once index 11 is out.
    req_valid = 3'b111;
    step(1, 0, rs);
    chk("rst_run_ready", 64'(rs), 64'(0));
    req_valid = '0;
    begin
      int n = 0;
      while (!(rf_wen && rf_wsel == AW'(11)) && n < 40) begin step(0, 0, rs); n++; end
      chk("reach_cnt12_timeout", 64'(n < 40), 64'(1));
    end
    wlog.delete(); bcnt = 0;
    step(1, 0, rs);
    begin
      int n = 0;
      while (busy && n < 40) begin step(0, 0, rs); n++; end
      chk("mid_rst_sweep_timeout", 64'(n < 40), 64'(1));
    end
    chk_sweep("mid_rst_sweep");

    // Randomised traffic; requesters hold their request until they see ready.
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int t = 0; t < 1500; t++) begin
      bit r, c;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          psel[i] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
          pdat[i] = $urandom;
        end
        req_valid[i] = pend[i];
        req_sel[i*AW +: AW] = psel[i];
        req_data[i*DW +: DW] = pdat[i];
      end
      r = ($urandom_range(0, 127) == 0);
      c = ($urandom_range(0, 63) == 0);
      step(r, c, rs);
      for (int i = 0; i < N; i++) if (rs[i]) pend[i] = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
